// File: rtl/btn_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : btn_intr_ctrl
// Description : Turns the debounced push-button level into one-cycle edge
//               pulses and a queued interrupt request with an acknowledge
//               handshake for the TramelBlaze counter processor. Presses are
//               held in a saturating pending counter. After every accepted
//               acknowledge the request drops for at least one cycle, so each
//               queued press is seen by the processor as a fresh request.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   PEND_W    width of the pending-press counter (saturates at 2^PEND_W-1)
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   db_in     debounced button level, synchronous to clk
//   intr_ack  processor interrupt acknowledge (may be held high)
//   clr_ovf   clears the sticky overflow flag
//   ped_rise  one-cycle pulse per debounced rising edge
//   ped_fall  one-cycle pulse per debounced falling edge
//   intr      interrupt request level to the processor
//   pend_cnt  number of unacknowledged presses
//   ovf       sticky: a press arrived while pend_cnt was saturated
// ============================================================================
module btn_intr_ctrl #(
  parameter int PEND_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              db_in,
  input  logic              intr_ack,
  input  logic              clr_ovf,
  output logic              ped_rise,
  output logic              ped_fall,
  output logic              intr,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf
);

  localparam logic [PEND_W-1:0] c_CNT_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] c_CNT_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACKD = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_db_prev;
  logic              r_ack_prev;
  logic              r_armed;
  logic [PEND_W-1:0] r_cnt;
  logic [PEND_W-1:0] w_cnt_next;
  logic              r_ovf;
  logic              w_ovf_next;
  logic              r_ped_rise;
  logic              r_ped_fall;
  logic              r_intr;

  logic              w_rise;
  logic              w_fall;
  logic              w_ack_edge;
  logic              w_ack_acc;

  // r_armed stays low after reset until db_in has been sampled low once.
  // A level that is already high when reset releases is therefore never
  // mistaken for a press; the button must fall and rise again.
  assign w_rise     = db_in & ~r_db_prev & r_armed;
  assign w_fall     = ~db_in & r_db_prev;
  assign w_ack_edge = intr_ack & ~r_ack_prev;
  // Only an acknowledge edge seen while requesting retires a press.
  assign w_ack_acc  = w_ack_edge & (r_state == S_REQ);

  // Pending counter, overflow flag and next state.
  always_comb begin
    w_cnt_next   = r_cnt;
    w_ovf_next   = r_ovf & ~clr_ovf;
    w_state_next = r_state;

    if (w_rise && !w_ack_acc) begin
      // A press into a saturated counter is lost but recorded; this wins
      // over a coincident clear.
      if (r_cnt == c_CNT_MAX) begin
        w_ovf_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end else if (w_ack_acc && !w_rise) begin
      // REQ is only ever entered with a nonzero count; the guard simply
      // keeps the counter from wrapping if that invariant were broken.
      if (r_cnt != c_CNT_ZERO) begin
        w_cnt_next = r_cnt - 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_cnt_next != c_CNT_ZERO) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ack_edge) begin
          w_state_next = S_ACKD;
        end
      end
      S_ACKD: begin
        // Hold off the next request until the acknowledge is released so
        // the processor always sees a low-to-high transition on intr.
        if (!intr_ack) begin
          w_state_next = (r_cnt != c_CNT_ZERO) ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_db_prev  <= 1'b0;
      r_ack_prev <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_ped_rise <= 1'b0;
      r_ped_fall <= 1'b0;
      r_intr     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_db_prev  <= db_in;
      r_ack_prev <= intr_ack;
      if (!db_in) begin
        r_armed <= 1'b1;
      end
      r_cnt      <= w_cnt_next;
      r_ovf      <= w_ovf_next;
      r_ped_rise <= w_rise;
      r_ped_fall <= w_fall;
      // intr is a registered decode of the state being entered, so it
      // changes on the same edge as the state.
      r_intr     <= (w_state_next == S_REQ);
    end
  end

  assign ped_rise = r_ped_rise;
  assign ped_fall = r_ped_fall;
  assign intr     = r_intr;
  assign pend_cnt = r_cnt;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_btn_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_intr_ctrl
// Description : Self-checking bench for btn_intr_ctrl. A behavioural model
//               computes the expected output vector for each driven cycle and
//               queues it; the vector is popped and compared after the clock
//               edge. Directed checks cover the key points of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_intr_ctrl;

  localparam int PEND_W  = 4;
  localparam int MAXC    = 15;
  localparam int ST_IDLE = 0;
  localparam int ST_REQ  = 1;
  localparam int ST_ACKD = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              db_in;
  logic              intr_ack;
  logic              clr_ovf;
  logic              ped_rise;
  logic              ped_fall;
  logic              intr;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  // reference model state
  logic m_dbp;
  logic m_ackp;
  logic m_armed;
  logic m_ovf;
  int   m_st;
  int   m_cnt;

  btn_intr_ctrl #(.PEND_W(PEND_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .db_in    (db_in),
    .intr_ack (intr_ack),
    .clr_ovf  (clr_ovf),
    .ped_rise (ped_rise),
    .ped_fall (ped_fall),
    .intr     (intr),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    m_dbp   = 1'b0;
    m_ackp  = 1'b0;
    m_armed = 1'b0;
    m_ovf   = 1'b0;
    m_st    = ST_IDLE;
    m_cnt   = 0;
  endtask

  // Advance the model by one clock with the given inputs and queue the
  // expected {ped_rise, ped_fall, intr, pend_cnt, ovf}.
  task automatic model_push(input logic db, input logic ack, input logic clr);
    logic rise, fall, aedge, acc, no;
    int   nc, ns;
    rise  = db && !m_dbp && m_armed;
    fall  = !db && m_dbp;
    aedge = ack && !m_ackp;
    acc   = aedge && (m_st == ST_REQ);
    nc    = m_cnt;
    no    = clr ? 1'b0 : m_ovf;
    if (rise && !acc) begin
      if (m_cnt == MAXC) no = 1'b1;
      else               nc = m_cnt + 1;
    end else if (acc && !rise) begin
      nc = m_cnt - 1;
    end
    ns = m_st;
    if (m_st == ST_IDLE) begin
      if (nc != 0) ns = ST_REQ;
    end else if (m_st == ST_REQ) begin
      if (aedge) ns = ST_ACKD;
    end else begin
      if (!ack) ns = (m_cnt != 0) ? ST_REQ : ST_IDLE;
    end
    m_dbp  = db;
    m_ackp = ack;
    if (!db) m_armed = 1'b1;
    m_cnt  = nc;
    m_ovf  = no;
    m_st   = ns;
    exp_q.push_back({rise, fall, (ns == ST_REQ), nc[3:0], no});
  endtask

  task automatic cycle(input logic db, input logic ack, input logic clr);
    logic [7:0] e;
    db_in    = db;
    intr_ack = ack;
    clr_ovf  = clr;
    model_push(db, ack, clr);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got no expected entry at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_vec", {24'd0, ped_rise, ped_fall, intr, pend_cnt, ovf}, {24'd0, e});
    end
  endtask

  task automatic press();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ack_pulse();
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    db_in    = 1'b0;
    intr_ack = 1'b0;
    clr_ovf  = 1'b0;
    mdl_reset();
    @(posedge clk);
    #1;
    chk("rst_ped_rise", {31'd0, ped_rise}, 32'd0);
    chk("rst_ped_fall", {31'd0, ped_fall}, 32'd0);
    chk("rst_intr",     {31'd0, intr},     32'd0);
    chk("rst_pend",     {28'd0, pend_cnt}, 32'd0);
    chk("rst_ovf",      {31'd0, ovf},      32'd0);
    #2;
    rst = 1'b0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    // single press held 20 cycles, then ack held 3 cycles
    cycle(1'b1, 1'b0, 1'b0);
    chk("press_rise", {31'd0, ped_rise}, 32'd1);
    chk("press_cnt",  {28'd0, pend_cnt}, 32'd1);
    chk("press_intr", {31'd0, intr},     32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("press_rise_once", {31'd0, ped_rise}, 32'd0);
    repeat (18) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("ack_intr_low", {31'd0, intr},     32'd0);
    chk("ack_cnt",      {28'd0, pend_cnt}, 32'd0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("ack_idle_intr", {31'd0, intr}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("fall_pulse", {31'd0, ped_fall}, 32'd1);
    chk("fall_cnt",   {28'd0, pend_cnt}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);

    // queue of three presses, then three single-cycle acks
    repeat (3) press();
    chk("q3_cnt",  {28'd0, pend_cnt}, 32'd3);
    chk("q3_intr", {31'd0, intr},     32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      chk("q3_ack_intr", {31'd0, intr},     32'd0);
      chk("q3_ack_cnt",  {28'd0, pend_cnt}, 32'(2 - i));
      cycle(1'b0, 1'b0, 1'b0);
      chk("q3_rereq", {31'd0, intr}, (i < 2) ? 32'd1 : 32'd0);
      cycle(1'b0, 1'b0, 1'b0);
    end

    // ack edge in IDLE is ignored; held ack retires one press only
    cycle(1'b0, 1'b1, 1'b0);
    chk("idle_ack_cnt",  {28'd0, pend_cnt}, 32'd0);
    chk("idle_ack_intr", {31'd0, intr},     32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (2) press();
    repeat (10) cycle(1'b0, 1'b1, 1'b0);
    chk("held_ack_cnt",  {28'd0, pend_cnt}, 32'd1);
    chk("held_ack_intr", {31'd0, intr},     32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("held_rereq", {31'd0, intr}, 32'd1);
    ack_pulse();
    chk("held_done", {28'd0, pend_cnt}, 32'd0);

    // press and accepted ack on the same edge
    repeat (2) press();
    cycle(1'b1, 1'b1, 1'b0);
    chk("sim_cnt",  {28'd0, pend_cnt}, 32'd2);
    chk("sim_intr", {31'd0, intr},     32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("sim_rereq", {31'd0, intr},     32'd1);
    chk("sim_cnt2",  {28'd0, pend_cnt}, 32'd2);
    cycle(1'b0, 1'b0, 1'b0);
    repeat (2) ack_pulse();
    chk("sim_done", {28'd0, pend_cnt}, 32'd0);

    // saturation and overflow flag
    repeat (16) press();
    chk("sat_cnt", {28'd0, pend_cnt}, 32'd15);
    chk("sat_ovf", {31'd0, ovf},      32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("clr_ovf", {31'd0, ovf}, 32'd0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("ovf_wins", {31'd0, ovf},      32'd1);
    chk("sat_hold", {28'd0, pend_cnt}, 32'd15);
    cycle(1'b0, 1'b0, 1'b0);

    // bring the count to 5 and enter ACKD with the button held high
    repeat (10) ack_pulse();
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("ackd_cnt",  {28'd0, pend_cnt}, 32'd5);
    chk("ackd_intr", {31'd0, intr},     32'd0);

    // asynchronous reset mid-ACKD
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cnt",  {28'd0, pend_cnt}, 32'd0);
    chk("arst_ovf",  {31'd0, ovf},      32'd0);
    chk("arst_intr", {31'd0, intr},     32'd0);
    chk("arst_rise", {31'd0, ped_rise}, 32'd0);
    chk("arst_fall", {31'd0, ped_fall}, 32'd0);
    mdl_reset();
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (2) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("post_rst_norise", {31'd0, ped_rise}, 32'd0);
    chk("post_rst_cnt",    {28'd0, pend_cnt}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("post_rst_fall", {31'd0, ped_fall}, 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    chk("post_rst_rise", {31'd0, ped_rise}, 32'd1);
    chk("post_rst_cnt1", {28'd0, pend_cnt}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/btn_intr_ctrl.md
# btn_intr_ctrl

Converts the debounced push-button level from the debounce stage into single-cycle edge pulses and a queued, acknowledge-handshaken interrupt request for the TramelBlaze counter processor. Each debounced press is counted in a saturating pending counter. The interrupt line stays high until the processor acknowledges it. After each acknowledge the line drops for at least one cycle, so every queued press re-presents as a fresh request. The block sits directly between the debounce stage output and the processor's interrupt/acknowledge pins.

## Interface
Parameters:
- PEND_W, default 4: width of the pending-press counter; saturates at 2^PEND_W-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- db_in  input  1  debounced button level; synchronous to clk; resets low upstream.
- intr_ack  input  1  processor interrupt acknowledge; may be held high for any number of cycles.
- clr_ovf  input  1  clears sticky overflow flag.
- ped_rise  output  1  one-cycle pulse per debounced rising edge.
- ped_fall  output  1  one-cycle pulse per debounced falling edge.
- intr  output  1  interrupt request level to processor.
- pend_cnt  output  PEND_W  number of unacknowledged presses.
- ovf  output  1  sticky: a press arrived while pend_cnt was saturated.

## Operation
Edge detection:
- db_prev and ack_prev are registered copies of db_in and intr_ack; both reset to 0.
- rise = db_in & ~db_prev; fall = ~db_in & db_prev.
- ack_edge = intr_ack & ~ack_prev.
- ped_rise and ped_fall are registered versions of rise and fall.

Pending counter, updated at each clock edge:
- rise and no accepted ack: +1. If already at max, hold and set ovf.
- Accepted ack and no rise: -1.
- rise and accepted ack together: unchanged. No ovf, even at max.
- An ack is accepted only on ack_edge while in state REQ.

Overflow flag:
- clr_ovf clears ovf.
- A new overflow in the same cycle as clr_ovf wins; ovf is set.

FSM states:
- IDLE (intr=0): pending count next value nonzero -> REQ.
- REQ (intr=1): ack_edge -> ACKD, with the decrement applied.
- ACKD (intr=0): wait while intr_ack=1. When intr_ack is sampled 0: -> REQ if pend_cnt != 0, else -> IDLE.
- ack_edge in IDLE or ACKD is ignored; no decrement.
- Presses in ACKD still increment the count.
- Unused state encodings -> IDLE.

## Timing
- Reset values: ped_rise=0, ped_fall=0, intr=0, pend_cnt=0, ovf=0, state IDLE, db_prev=0, ack_prev=0.
- Press latency: db_in sampled 1 (with db_prev=0) at edge k. After edge k, ped_rise=1 for exactly one cycle. pend_cnt has incremented. intr=1 if the FSM was in IDLE.
- Acknowledge latency: ack_edge sampled at edge j in REQ. After edge j, intr=0 and pend_cnt has decremented.
- Re-request: intr low for at least one full cycle after every accepted ack. intr re-asserts after the first edge at which intr_ack is sampled 0, provided count != 0.
- A held ack causes exactly one decrement.
- Falling edge: ped_fall high for one cycle after the edge at which the fall is sampled. It does not affect the count.
- Reset mid-operation: all state clears immediately and asynchronously. Pending presses are discarded.

## Test plan
- Single press: db_in 0->1 held 20 cycles. Expect: ped_rise one cycle; pend_cnt=1; intr=1. Then ack high 3 cycles. Expect: intr=0 after the first ack edge; pend_cnt=0; IDLE after ack drops.
- Queue of 3 presses with no ack. Expect: pend_cnt=3, intr=1. Then 3 ack pulses of 1 cycle each. Expect: intr drops one cycle per ack, re-asserts twice, ends at 0 with intr=0.
- Saturation, PEND_W=4: 16 presses. Expect: pend_cnt=15, ovf=1. Then clr_ovf pulse -> ovf=0. Then clr_ovf coincident with a 17th press -> ovf=1.
- Simultaneous: press rising edge at the same edge as ack_edge in REQ with pend_cnt=2. Expect: pend_cnt stays 2; intr low one cycle, then high again.
- Ack misuse: ack_edge in IDLE. Expect: no change, pend_cnt=0. Ack held high 10 cycles in REQ with pend_cnt=2. Expect: pend_cnt=1 exactly once.
- Async reset: assert rst mid-ACKD with pend_cnt=5. Expect: all outputs 0 immediately. After release, db_in still high produces no ped_rise until it falls and rises again.
